tff_bank_sequencer: RTL and testbench
=====================================

# tff_bank_sequencer

- Sequences a bank of WIDTH external T flip-flops into a command-driven up/down counter.
- Each flip-flop has active-low preset and clear.
- Generates per-bit T, preset and clear drives, and keeps a shadow copy of the bank value.
- Checks the flip-flop Q feedback against the shadow every cycle.
- Sits between a command source (valid/ready) and the T flip-flop bank. The flip-flops are clocked by the same clock.

## Interface

Parameters:

- WIDTH, default 4: number of T flip-flops in the bank.
- CNT_W, default 8: width of the step-count field.

Ports (clock and reset first):

- input_clock  in  1  sole clock; all state updates on its rising edge.
- input_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  command code: 00 UP, 01 DOWN, 10 LOAD, 11 CLEAR.
- cmd_data  in  WIDTH  value for LOAD; ignored otherwise.
- cmd_steps  in  CNT_W  number of count steps for UP/DOWN; ignored otherwise.
- q_fb  in  WIDTH  Q outputs of the flip-flop bank.
- t_out  out  WIDTH  T inputs to the bank.
- preset_n  out  WIDTH  active-low preset per bit.
- clear_n  out  WIDTH  active-low clear per bit.
- shadow  out  WIDTH  controller's expected bank value.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a command completes.
- mismatch  out  1  sticky: q_fb disagreed with shadow in a checked state.

## Operation

All outputs are a Moore decode of registered state; none is combinational from inputs.

States:

- FORCE
  - preset_n[i] = ~pat[i], clear_n[i] = pat[i] (bits with pat=1 preset, bits with pat=0 cleared).
  - Lasts exactly one cycle, then goes to SETTLE.
- SETTLE
  - All preset_n/clear_n high, t_out = 0.
  - Goes to DONE if entered from a command, to IDLE if entered from reset.
- IDLE
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready:
    - LOAD: pat ← cmd_data, shadow ← cmd_data, go to FORCE.
    - CLEAR: pat ← 0, shadow ← 0, go to FORCE.
    - UP/DOWN: remaining ← cmd_steps, dir latched; go to COUNT if cmd_steps ≠ 0, else DONE.
- COUNT
  - t_out = shadow ^ nxt, where nxt = shadow ± 1 mod 2^WIDTH.
  - At each edge: shadow ← nxt, remaining ← remaining − 1.
  - Goes to DONE when remaining reaches 0 at that edge.
- DONE
  - done = 1, t_out = 0, then goes to IDLE.

Default output values:

- Outside FORCE: preset_n and clear_n are all ones.
- Outside COUNT: t_out = 0.
- cmd_ready is high only in IDLE.

Arithmetic and wrap-around:

- UP from 2^WIDTH−1 goes to 0, with t_out all ones.
- DOWN from 0 goes to 2^WIDTH−1, with t_out all ones.

Mismatch check:

- In IDLE, COUNT and DONE, if q_fb ≠ shadow, mismatch ← 1.
- Not checked in FORCE or SETTLE (the asynchronous preset/clear is settling).
- Cleared only by reset.

Reset:

- While input_reset is high at an edge: state ← FORCE (from reset), pat ← 0, shadow ← 0, mismatch ← 0, remaining ← 0. The bank is held cleared for as long as reset is high.
- Asserting reset mid-command abandons the command, and no done pulse is issued.

## Timing

Reset and reset release:

- Values while reset is held: state FORCE; clear_n = 0; preset_n all ones; t_out = 0; shadow = 0; busy = 1; cmd_ready = 0; done = 0; mismatch = 0.
- After release: 1 cycle FORCE, 1 cycle SETTLE, then IDLE. cmd_ready rises on the 3rd cycle after release.

Command latency, counted from the accept edge:

- LOAD/CLEAR: FORCE (cycle 1), SETTLE (2), DONE (3, done high), IDLE (4).
- UP/DOWN with N > 0: COUNT for cycles 1..N, DONE at N+1, IDLE at N+2.
- UP/DOWN with N = 0: DONE at cycle 1, no toggles.

Bank behaviour:

- The bank samples t_out at the same edge the controller updates shadow, so in correct operation q_fb equals shadow in every checked state.
- A new command may be accepted on the first IDLE cycle; there is no back-to-back acceptance from DONE.

Handshake:

- cmd_valid is sampled only when cmd_ready = 1.
- cmd_op, cmd_data and cmd_steps are captured at the accept edge; later changes have no effect.

## Test plan

- Reset:
  - Stimulus: hold reset 3 cycles, release; model bank tracks t_out/preset_n/clear_n.
  - Response: clear_n = 0000 during reset; cmd_ready high at cycle 3 after release; shadow = 0; mismatch = 0; no done pulse.
- LOAD:
  - Stimulus: LOAD cmd_data = 1010.
  - Response: one FORCE cycle with preset_n = 0101, clear_n = 1010; done at cycle 3; q_fb = shadow = 1010.
- UP with wrap:
  - Stimulus: LOAD 1110, then UP steps = 3.
  - Response: t_out = 0001, 1111, 0001 on consecutive cycles; shadow 1111 → 0000 → 0001; done at cycle 4; mismatch = 0.
- DOWN with wrap, and zero steps:
  - Stimulus: CLEAR, DOWN steps = 1, then DOWN steps = 0.
  - Response: first command gives t_out = 1111, shadow = 1111, done at cycle 2. Second gives done at cycle 1, t_out stays 0000, shadow unchanged.
- Fault injection:
  - Stimulus: model bank ignores T on bit 2 during UP steps = 4 from 0.
  - Response: mismatch rises by the first checked cycle where q_fb ≠ shadow and stays high until reset.
- Reset mid-count:
  - Stimulus: UP steps = 200, assert reset at COUNT cycle 5.
  - Response: no done pulse; shadow = 0; bank cleared; cmd_ready returns 3 cycles after release; command inputs ignored while not ready.

Source files
------------

// File: rtl/tff_bank_sequencer.sv
// Drives a bank of external T flip-flops as a command-driven up/down counter,
// keeping a shadow of the expected bank value and flagging Q feedback disagreement.
module tff_bank_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             input_clock,
  input  logic             input_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] t_out,
  output logic [WIDTH-1:0] preset_n,
  output logic [WIDTH-1:0] clear_n,
  output logic [WIDTH-1:0] shadow,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [2:0]       dbg_state
);

  // Command handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends on state only, never on cmd_valid.
  localparam logic [1:0] OP_UP    = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    ST_FORCE  = 3'd0,
    ST_SETTLE = 3'd1,
    ST_IDLE   = 3'd2,
    ST_COUNT  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             from_cmd_q, from_cmd_d;
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] nxt;
  logic             checked;

  assign nxt     = dir_q ? (shadow_q - WIDTH'(1)) : (shadow_q + WIDTH'(1));
  // Feedback is ignored while the asynchronous preset/clear may still be settling.
  assign checked = (state_q == ST_IDLE) || (state_q == ST_COUNT) || (state_q == ST_DONE);

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    shadow_d   = shadow_q;
    rem_d      = rem_q;
    dir_d      = dir_q;
    from_cmd_d = from_cmd_q;
    mismatch_d = mismatch_q | (checked && (q_fb != shadow_q));
    case (state_q)
      ST_FORCE:  state_d = ST_SETTLE;
      ST_SETTLE: state_d = from_cmd_q ? ST_DONE : ST_IDLE;
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_LOAD: begin
              pat_d      = cmd_data;
              shadow_d   = cmd_data;
              from_cmd_d = 1'b1;
              state_d    = ST_FORCE;
            end
            OP_CLEAR: begin
              pat_d      = '0;
              shadow_d   = '0;
              from_cmd_d = 1'b1;
              state_d    = ST_FORCE;
            end
            default: begin
              rem_d   = cmd_steps;
              dir_d   = (cmd_op == OP_DOWN);
              state_d = (cmd_steps != '0) ? ST_COUNT : ST_DONE;
            end
          endcase
        end
      end
      ST_COUNT: begin
        shadow_d = nxt;
        rem_d    = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default: begin
        from_cmd_d = 1'b0;
        state_d    = ST_FORCE;
      end
    endcase
  end

  always_ff @(posedge input_clock) begin
    if (input_reset) begin
      state_q    <= ST_FORCE;
      pat_q      <= '0;
      shadow_q   <= '0;
      rem_q      <= '0;
      dir_q      <= 1'b0;
      from_cmd_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      shadow_q   <= shadow_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      from_cmd_q <= from_cmd_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Moore decode: every output comes from registered state only.
  always_comb begin
    t_out    = '0;
    preset_n = '1;
    clear_n  = '1;
    case (state_q)
      ST_FORCE: begin
        preset_n = ~pat_q;
        clear_n  = pat_q;
      end
      ST_COUNT: t_out = shadow_q ^ nxt;
      default: ;
    endcase
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign shadow    = shadow_q;
  assign mismatch  = mismatch_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_tff_bank_sequencer.sv
// Directed bench for tff_bank_sequencer with a behavioural T flip-flop bank,
// a done-driven scoreboard and per-command latency/waveform checks.
module tb_tff_bank_sequencer;
  localparam int W  = 4;
  localparam int CW = 8;

  logic          input_clock;
  logic          input_reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [W-1:0]  cmd_data;
  logic [CW-1:0] cmd_steps;
  logic [W-1:0]  q_fb;
  logic [W-1:0]  t_out;
  logic [W-1:0]  preset_n;
  logic [W-1:0]  clear_n;
  logic [W-1:0]  shadow;
  logic          busy;
  logic          done;
  logic          mismatch;
  logic [2:0]    dbg_state;

  logic          fault_bit2;
  logic [W-1:0]  q_reg;

  int total;
  int bad;
  int lat;
  logic [W:0]   exp_q[$];   // {mismatch, shadow} expected at each done pulse
  logic [W-1:0] tr_t[16];
  logic [W-1:0] tr_sh[16];
  logic [W-1:0] tr_pn[16];
  logic [W-1:0] tr_cn[16];

  tff_bank_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
    .input_clock(input_clock),
    .input_reset(input_reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_data(cmd_data),
    .cmd_steps(cmd_steps),
    .q_fb(q_fb),
    .t_out(t_out),
    .preset_n(preset_n),
    .clear_n(clear_n),
    .shadow(shadow),
    .busy(busy),
    .done(done),
    .mismatch(mismatch),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    input_clock = 1'b0;
    forever #5 input_clock = ~input_clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // T flip-flop bank: async active-low clear/preset, optional stuck T on bit 2.
  always @(posedge input_clock) begin
    for (int i = 0; i < W; i++) begin
      if (!clear_n[i])                            q_reg[i] <= 1'b0;
      else if (!preset_n[i])                      q_reg[i] <= 1'b1;
      else if (t_out[i] && !(fault_bit2 && i == 2)) q_reg[i] <= ~q_reg[i];
    end
  end

  always_comb begin
    q_fb = q_reg;
    for (int i = 0; i < W; i++) begin
      if (!clear_n[i])       q_fb[i] = 1'b0;
      else if (!preset_n[i]) q_fb[i] = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge input_clock) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending command");
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        check("done_shadow", 32'(shadow), 32'(e[W-1:0]));
        check("done_mismatch", 32'(mismatch), 32'(e[W]));
      end
    end
  end

  // Reset held for `hold` edges with a not-ready command asserted; checks the
  // held values and the release timeline.
  task automatic do_reset(input int hold);
    input_reset = 1'b1;
    cmd_valid   = 1'b1;
    cmd_op      = 2'b10;
    cmd_data    = 4'b0110;
    cmd_steps   = 8'd7;
    repeat (hold) @(negedge input_clock);
    check("rst_clear_n", 32'(clear_n), 32'h0);
    check("rst_preset_n", 32'(preset_n), 32'hF);
    check("rst_t_out", 32'(t_out), 32'h0);
    check("rst_shadow", 32'(shadow), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);
    check("rst_ready", 32'(cmd_ready), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_mismatch", 32'(mismatch), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    check("rst_bank", 32'(q_fb), 32'h0);
    input_reset = 1'b0;
    #1;
    check("rel_c1_ready", 32'(cmd_ready), 32'h0);
    @(negedge input_clock);
    check("rel_c2_ready", 32'(cmd_ready), 32'h0);
    @(negedge input_clock);
    check("rel_c3_ready", 32'(cmd_ready), 32'h1);
    check("rel_shadow", 32'(shadow), 32'h0);
    check("rel_mismatch", 32'(mismatch), 32'h0);
    cmd_valid = 1'b0;
    @(negedge input_clock);
    check("rel_no_accept", 32'(busy), 32'h0);
  endtask

  // driver: issues one command at a negedge, traces cycles 1.. until done
  task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] data,
                         input logic [CW-1:0] steps, input logic [W:0] exp,
                         input int exp_lat, input logic [W-1:0] exp_bank);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge input_clock);
      guard++;
    end
    check("ready_at_issue", 32'(cmd_ready), 32'h1);
    exp_q.push_back(exp);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_steps = steps;
    @(posedge input_clock);
    lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge input_clock);
      if (k == 1) begin
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_data  = W'($urandom_range(0, 15));
        cmd_steps = CW'($urandom_range(0, 255));
      end
      if (k < 16) begin
        tr_t[k]  = t_out;
        tr_sh[k] = shadow;
        tr_pn[k] = preset_n;
        tr_cn[k] = clear_n;
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("bank_at_done", 32'(q_fb), 32'(exp_bank));
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    fault_bit2 = 1'b0;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_data   = '0;
    cmd_steps  = '0;

    do_reset(3);

    // LOAD 1010
    run_cmd(2'b10, 4'b1010, 8'd0, {1'b0, 4'b1010}, 3, 4'b1010);
    check("load_force_pn", 32'(tr_pn[1]), 32'h5);
    check("load_force_cn", 32'(tr_cn[1]), 32'hA);
    check("load_settle_pn", 32'(tr_pn[2]), 32'hF);
    check("load_settle_cn", 32'(tr_cn[2]), 32'hF);

    // LOAD 1110 then UP 3 wrapping through 0
    run_cmd(2'b10, 4'b1110, 8'd0, {1'b0, 4'b1110}, 3, 4'b1110);
    run_cmd(2'b00, 4'b0000, 8'd3, {1'b0, 4'b0001}, 4, 4'b0001);
    check("up_t1", 32'(tr_t[1]), 32'h1);
    check("up_t2", 32'(tr_t[2]), 32'hF);
    check("up_t3", 32'(tr_t[3]), 32'h1);
    check("up_t_done", 32'(tr_t[4]), 32'h0);
    check("up_sh2", 32'(tr_sh[2]), 32'hF);
    check("up_sh3", 32'(tr_sh[3]), 32'h0);

    // CLEAR, DOWN 1 wrapping to 1111, DOWN 0
    run_cmd(2'b11, 4'b0101, 8'd9, {1'b0, 4'b0000}, 3, 4'b0000);
    run_cmd(2'b01, 4'b0000, 8'd1, {1'b0, 4'b1111}, 2, 4'b1111);
    check("down_t1", 32'(tr_t[1]), 32'hF);
    check("down_t_done", 32'(tr_t[2]), 32'h0);
    run_cmd(2'b01, 4'b0000, 8'd0, {1'b0, 4'b1111}, 1, 4'b1111);
    check("down0_t1", 32'(tr_t[1]), 32'h0);

    // DOWN 3: 1111 -> 1110 -> 1101 -> 1100
    run_cmd(2'b01, 4'b0000, 8'd3, {1'b0, 4'b1100}, 4, 4'b1100);
    check("down3_t2", 32'(tr_t[2]), 32'h3);
    check("down3_sh3", 32'(tr_sh[3]), 32'hD);

    // reset during a long UP count, at COUNT cycle 5
    run_cmd(2'b10, 4'b0101, 8'd0, {1'b0, 4'b0101}, 3, 4'b0101);
    @(negedge input_clock);
    check("long_ready", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_steps = 8'd200;
    @(posedge input_clock);
    @(negedge input_clock);
    cmd_valid = 1'b0;
    repeat (4) @(negedge input_clock);
    check("long_busy_c5", 32'(busy), 32'h1);
    check("long_shadow_c5", 32'(shadow), 32'h9);
    do_reset(2);

    // fault: bank ignores T on bit 2 during UP 4 from 0
    fault_bit2 = 1'b1;
    run_cmd(2'b00, 4'b0000, 8'd4, {1'b0, 4'b0100}, 5, 4'b0000);
    @(negedge input_clock);
    check("fault_mismatch_rise", 32'(mismatch), 32'h1);
    repeat (3) @(negedge input_clock);
    check("fault_mismatch_hold", 32'(mismatch), 32'h1);
    fault_bit2 = 1'b0;
    run_cmd(2'b01, 4'b0000, 8'd0, {1'b1, 4'b0100}, 1, 4'b0000);
    do_reset(2);

    repeat (3) @(negedge input_clock);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
